// File: rtl/display_scanner_pkg.sv
// Shared stopwatch definitions: seven-segment patterns and output polarity helpers.
// Segment vectors are active-high internally, bit0 = a through bit6 = g.
package display_scanner_pkg;

    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    localparam logic [6:0] SEG_BLANK    = 7'h00;
    localparam logic [6:0] SEG_OVERFLOW = 7'h40;

    // Convert an active-high "on" request into the pin level for the board polarity.
    function automatic logic drive_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

    function automatic logic [6:0] seg_level(input logic [6:0] on, input logic active_low);
        return on ^ {7{active_low}};
    endfunction

endpackage

// File: rtl/display_scanner_seg7_decode.sv
// Combinational hex-to-seven-segment decode; codes above 15 show only segment g.
module seg7_decode
    import display_scanner_pkg::*;
#(
    parameter int DIGIT_BITS = 4
) (
    input  logic [DIGIT_BITS-1:0] code,
    output logic [6:0]            seg
);

    logic over;

    generate
        if (DIGIT_BITS > 4) begin : g_wide
            assign over = |code[DIGIT_BITS-1:4];
        end else begin : g_narrow
            assign over = 1'b0;
        end
    endgenerate

    assign seg = over ? SEG_OVERFLOW : SEG_PATTERNS[code[3:0]];

endmodule

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner: prescaled digit rotation over a per-frame
// snapshot of the counter chain, with leading-zero blanking and registered outputs.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_BITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    input  logic                             blank_lz,
    output logic [NUM_DIGITS-1:0]            anode_out,
    output logic [6:0]                       seg_out,
    output logic                             dp_out,
    output logic                             frame_done
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]             prescaler;
    logic [IDX_W-1:0]             index;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]        snap_dp;

    logic                         tc;
    logic                         last_digit;
    logic [DIGIT_BITS-1:0]        cur_digit;
    logic                         cur_dp;
    logic                         cur_blank;
    logic [NUM_DIGITS-1:0]        blank_mask;
    logic [NUM_DIGITS-1:0]        anode_level;
    logic                         zero_run;
    logic [6:0]                   dec_seg;

    assign tc         = (prescaler == PRE_LAST);
    assign last_digit = (index == IDX_LAST);

    // Blanking walks down from the most significant digit and stops at the first
    // digit that is non-zero or carries a decimal point; digit 0 always shows.
    always_comb begin
        cur_digit   = '0;
        cur_dp      = 1'b0;
        cur_blank   = 1'b0;
        blank_mask  = '0;
        anode_level = '0;
        zero_run    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_digits[i*DIGIT_BITS +: DIGIT_BITS] == '0) && !snap_dp[i];
            if (i >= 1) begin
                blank_mask[i] = blank_lz && zero_run;
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_level[i] = drive_level(index == IDX_W'(i), ACTIVE_LOW);
            if (index == IDX_W'(i)) begin
                cur_digit = snap_digits[i*DIGIT_BITS +: DIGIT_BITS];
                cur_dp    = snap_dp[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    seg7_decode #(
        .DIGIT_BITS (DIGIT_BITS)
    ) u_decode (
        .code (cur_digit),
        .seg  (dec_seg)
    );

    // frame_done is a one-cycle strobe with no ready: it is high exactly in the
    // cycle after a new snapshot has been captured, and never while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            index       <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            frame_done  <= 1'b0;
            anode_out   <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_out     <= seg_level(SEG_BLANK, ACTIVE_LOW);
            dp_out      <= drive_level(1'b0, ACTIVE_LOW);
        end else begin
            frame_done <= 1'b0;
            if (enable) begin
                prescaler <= tc ? '0 : prescaler + 1'b1;
                if (tc) begin
                    index <= last_digit ? '0 : index + 1'b1;
                    if (last_digit) begin
                        snap_digits <= digits_in;
                        snap_dp     <= dp_in;
                        frame_done  <= 1'b1;
                    end
                end
                anode_out <= anode_level;
                seg_out   <= seg_level(cur_blank ? SEG_BLANK : dec_seg, ACTIVE_LOW);
                dp_out    <= drive_level(cur_dp && !cur_blank, ACTIVE_LOW);
            end else begin
                anode_out <= {NUM_DIGITS{ACTIVE_LOW}};
                seg_out   <= seg_level(SEG_BLANK, ACTIVE_LOW);
                dp_out    <= drive_level(1'b0, ACTIVE_LOW);
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: directed stimulus pushes per-cycle expected outputs
// into queues; a negedge monitor pops and compares them against two instances.
module tb_display_scanner;

    localparam int W = 29;   // {cycle[15:0], anode[3:0], seg[6:0], dp, frame_done}

    logic        clk = 1'b0;
    logic        rst, rst_al, enable, blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  anode_out, anode_al;
    logic [6:0]  seg_out, seg_al;
    logic        dp_out, dp_al, frame_done, frame_done_al;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_al_q[$];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    display_scanner #(
        .NUM_DIGITS (4), .DIGIT_BITS (4), .REFRESH_DIV (4), .ACTIVE_LOW (1'b0)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable), .digits_in (digits_in),
        .dp_in (dp_in), .blank_lz (blank_lz), .anode_out (anode_out),
        .seg_out (seg_out), .dp_out (dp_out), .frame_done (frame_done)
    );

    display_scanner #(
        .NUM_DIGITS (4), .DIGIT_BITS (4), .REFRESH_DIV (4), .ACTIVE_LOW (1'b1)
    ) dut_al (
        .clk (clk), .rst (rst_al), .enable (1'b1), .digits_in (16'h8888),
        .dp_in (4'b0000), .blank_lz (1'b0), .anode_out (anode_al),
        .seg_out (seg_al), .dp_out (dp_al), .frame_done (frame_done_al)
    );

    // driver tasks: expectations are given active-high and inverted for the active-low unit
    task automatic push_one(input bit al, input int c, input logic [3:0] an,
                            input logic [6:0] seg, input logic dp, input logic fd);
        logic [W-1:0] e;
        if (al) begin
            e = {16'(c), ~an, ~seg, ~dp, fd};
            exp_al_q.push_back(e);
        end else begin
            e = {16'(c), an, seg, dp, fd};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_slot(input bit al, input int start, input int len, input int k,
                             input logic [6:0] seg, input logic dp, input bit fd_last);
        for (int c = 0; c < len; c++)
            push_one(al, start + c, 4'(1 << k), seg, dp, fd_last && (c == len - 1));
    endtask

    task automatic push_off(input bit al, input int start, input int len);
        for (int c = 0; c < len; c++)
            push_one(al, start + c, 4'b0000, 7'h00, 1'b0, 1'b0);
    endtask

    task automatic push_frame(input bit al, input int start, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpv, input bit fd_last);
        push_slot(al, start,      4, 0, s0, dpv[0], 1'b0);
        push_slot(al, start + 4,  4, 1, s1, dpv[1], 1'b0);
        push_slot(al, start + 8,  4, 2, s2, dpv[2], 1'b0);
        push_slot(al, start + 12, 4, 3, s3, dpv[3], fd_last);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard
    task automatic compare_entry(input string name, input logic [W-1:0] e,
                                 input logic [3:0] an, input logic [6:0] seg,
                                 input logic dp, input logic fd);
        logic [12:0] got;
        got = {an, seg, dp, fd};
        checks++;
        if (e[28:13] != 16'(cyc) || got !== e[12:0]) begin
            errors++;
            $display("FAIL %s cyc=%0d exp_cyc=%0d got an=%b seg=%h dp=%b fd=%b exp an=%b seg=%h dp=%b fd=%b",
                     name, cyc, e[28:13], an, seg, dp, fd, e[12:9], e[8:2], e[1], e[0]);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][28:13]) <= cyc)
            compare_entry("main_scan", exp_q.pop_front(), anode_out, seg_out, dp_out, frame_done);
        while (exp_al_q.size() > 0 && int'(exp_al_q[0][28:13]) <= cyc)
            compare_entry("active_low_scan", exp_al_q.pop_front(), anode_al, seg_al, dp_al, frame_done_al);
    end

    initial begin
        rst       = 1'b1;
        rst_al    = 1'b1;
        enable    = 1'b1;
        blank_lz  = 1'b0;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;

        // reset state, empty first frame, then 4,3,2,1
        push_off(1'b0, 1, 2);
        push_frame(1'b0, 4,  7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 1'b1);
        push_frame(1'b0, 20, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 1'b1);
        // active-low unit showing 8888
        push_off(1'b1, 1, 2);
        push_frame(1'b1, 4,  7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 1'b1);
        push_frame(1'b1, 20, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);

        wait_cyc(3);
        rst    = 1'b0;
        rst_al = 1'b0;

        // mid-frame change: frame 20..35 keeps 1234, 0050 appears from 36
        wait_cyc(24);
        digits_in = 16'h0050;
        blank_lz  = 1'b1;
        push_frame(1'b0, 36, 7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000, 1'b1);

        // decimal point on digit 2 stops blanking there
        wait_cyc(40);
        dp_in = 4'b0100;
        push_frame(1'b0, 52, 7'h3F, 7'h6D, 7'h3F, 7'h00, 4'b0100, 1'b1);

        // enable drops for 10 cycles with one count left in slot 0
        wait_cyc(60);
        push_slot(1'b0, 68, 3, 0, 7'h3F, 1'b0, 1'b0);
        push_off(1'b0, 71, 10);
        push_slot(1'b0, 81, 1, 0, 7'h3F, 1'b0, 1'b0);
        push_slot(1'b0, 82, 4, 1, 7'h6D, 1'b0, 1'b0);
        push_slot(1'b0, 86, 4, 2, 7'h3F, 1'b1, 1'b0);
        push_slot(1'b0, 90, 4, 3, 7'h00, 1'b0, 1'b1);
        wait_cyc(70);
        enable = 1'b0;
        wait_cyc(80);
        enable = 1'b1;

        // reset during slot 2, no frame_done for the aborted frame
        push_slot(1'b0, 94,  4, 0, 7'h3F, 1'b0, 1'b0);
        push_slot(1'b0, 98,  4, 1, 7'h6D, 1'b0, 1'b0);
        push_slot(1'b0, 102, 1, 2, 7'h3F, 1'b1, 1'b0);
        push_off(1'b0, 103, 4);
        push_frame(1'b0, 107, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, 1'b1);
        push_frame(1'b0, 123, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 1'b1);
        wait_cyc(103);
        rst = 1'b1;
        wait_cyc(104);
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        wait_cyc(106);
        rst = 1'b0;

        wait_cyc(142);
        checks++;
        if (exp_q.size() + exp_al_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d pending, need 0",
                     exp_q.size() + exp_al_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions.
REQ-002 Parameter DIGIT_BITS, default 4: width of each digit code.
REQ-003 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; minimum 2.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, anode_out, seg_out and dp_out drive 0 for "on"; when 0, they drive 1 for "on".
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  scan enable; low blanks the display and freezes scanning.
REQ-008 digits_in  in  NUM_DIGITS*DIGIT_BITS  digit codes from the counter chain; digit i is bits [i*DIGIT_BITS +: DIGIT_BITS]; digit 0 is least significant and rightmost.
REQ-009 dp_in  in  NUM_DIGITS  decimal point request per digit.
REQ-010 blank_lz  in  1  leading-zero blanking enable.
REQ-011 anode_out  out  NUM_DIGITS  one-hot digit select (in active polarity).
REQ-012 seg_out  out  7  segments; bit0 = a through bit6 = g.
REQ-013 dp_out  out  1  decimal point segment.
REQ-014 frame_done  out  1  single-cycle pulse when a new snapshot is loaded.

Function
REQ-015 A prescaler shall count 0..REFRESH_DIV-1 while enable=1, then wrap to 0; the terminal count (tc) is prescaler == REFRESH_DIV-1.
REQ-016 On tc, the digit index shall advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 On tc with index == NUM_DIGITS-1, the snapshot registers shall load digits_in and dp_in, and frame_done shall be 1 in the following cycle only.
REQ-018 The displayed data shall come only from the snapshot, so a frame never mixes values from two counter states.
REQ-019 All outputs shall be registered: they reflect the index and snapshot from the previous cycle, with exactly 1 cycle of latency.
REQ-020 Exactly one anode shall be active, at position index, while enable=1.
REQ-021 seg_out shall use the hex decode: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-022 For DIGIT_BITS > 4, any code above 15 shall display segment g only.
REQ-023 Leading-zero blanking: when blank_lz=1, digit i (i >= 1) shall be blanked if snapshot digits i..NUM_DIGITS-1 are all 0 and their dp bits are all 0. Digit 0 is never blanked.
REQ-024 A blanked digit shall keep its anode active and drive all segments and dp off.
REQ-025 When enable=0: prescaler and index hold, all anodes are off, all segments are off, dp is off, and frame_done is 0. On re-enable, scanning resumes from the held state.
REQ-026 dp_out shall follow the snapshot dp bit of the current index unless the digit is blanked.

Reset
REQ-027 On rst: prescaler=0, index=0, snapshot digits=0, snapshot dp=0, frame_done=0, all anodes off, all segments off, dp off.
REQ-028 Asserting rst mid-frame shall abort the frame immediately; no frame_done pulse is produced for the aborted frame.

Structure
REQ-029 The segment patterns (16 x 7-bit constants) and the polarity helper shall live in the shared stopwatch package.
REQ-030 The hex-to-segment decode shall be one combinational sub-module, seg7_decode; the prescaler, index and snapshot logic shall stay in display_scanner.

Verification
REQ-031 Use REFRESH_DIV=4, NUM_DIGITS=4, ACTIVE_LOW=0. Release reset with digits_in=0x1234 -> anode_out = 0001, 0010, 0100, 1000, 0001, each held for 4 cycles; the first frame shows 0000; frame_done pulses once after the 16th slot cycle; the next frame shows 4,3,2,1 with seg 0x66, 0x4F, 0x5B, 0x06.
REQ-032 Change digits_in in mid-frame -> the displayed digits stay at the old snapshot until the frame_done cycle.
REQ-033 blank_lz=1, digits 0x0050, dp_in=0000 -> digits 3 and 2 show seg=0 with their anodes active; digit 1 shows 0x6D; digit 0 shows 0x3F. Then set dp_in=0100 -> digit 2 shows 0x3F with dp on.
REQ-034 Drop enable for 10 cycles in mid-slot -> all outputs off, prescaler held; after re-enable, the slot completes its remaining count.
REQ-035 Assert rst during slot 2 -> next cycle all outputs off and frame_done=0; after release, scanning restarts at anode 0001 with the snapshot at 0.
REQ-036 Run with ACTIVE_LOW=1 and digit value 8 -> seg_out=0x00, active anode bit=0, other anodes=1.
